// File: rtl/char_slot_scheduler_pkg.sv
// Shared types and constants for the character slot scheduler:
// FSM state encoding, requester ids and the default idle character.
package char_slot_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic [7:0] DEF_IDLE_CHAR = 8'h20;

endpackage

// File: rtl/char_slot_scheduler_slot_timer.sv
// Slot timer: counts unpaused clocks within one display slot and flags the
// last cycle of the slot. Clear has priority; the count saturates at TICK_DIV-1.
module char_slot_scheduler_slot_timer #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic slot_end
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign slot_end = (cnt_q == LAST);

endmodule

// File: rtl/char_slot_scheduler.sv
// Shares the displayed character between two requesters, round-robin,
// showing each accepted character for exactly one TICK_DIV-clock slot.
module char_slot_scheduler
  import char_slot_scheduler_pkg::*;
#(
  parameter int         TICK_DIV  = 25_000_000,
  parameter logic [7:0] IDLE_CHAR = DEF_IDLE_CHAR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_char0,
  input  logic [7:0] req_char1,
  output logic [1:0] req_ready,
  output logic [7:0] disp_char,
  output logic       disp_strobe,
  output logic       disp_src,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [7:0] disp_char_q, disp_char_d;
  logic       disp_src_q, disp_src_d;
  logic       disp_strobe_q, disp_strobe_d;
  logic       last_grant_q, last_grant_d;

  logic slot_end;
  logic tmr_clr;
  logic tmr_en;
  logic accept;
  logic grant_id;
  logic transfer;

  char_slot_scheduler_slot_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_slot_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .slot_end (slot_end)
  );

  assign accept = ((state_q == IDLE) || slot_end) && !pause;

  // Round-robin: a lone requester always wins; on contention the one not served last wins.
  always_comb begin
    grant_id  = REQ0;
    req_ready = 2'b00;
    if (req_valid == 2'b11) begin
      grant_id = ~last_grant_q;
    end else if (req_valid[1]) begin
      grant_id = REQ1;
    end
    if (accept && (req_valid != 2'b00)) begin
      req_ready = (grant_id == REQ1) ? 2'b10 : 2'b01;
    end
  end

  assign transfer = (req_ready != 2'b00);

  always_comb begin
    state_d       = state_q;
    disp_char_d   = disp_char_q;
    disp_src_d    = disp_src_q;
    disp_strobe_d = 1'b0;
    last_grant_d  = last_grant_q;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;

    if (!pause) begin
      unique case (state_q)
        IDLE: begin
          if (transfer) begin
            state_d = SHOW;
            tmr_clr = 1'b1;
          end
        end
        SHOW: begin
          if (slot_end) begin
            tmr_clr       = 1'b1;
            disp_strobe_d = 1'b1;
            if (!transfer) begin
              state_d     = IDLE;
              disp_char_d = IDLE_CHAR;
              disp_src_d  = REQ0;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (transfer) begin
        disp_char_d   = (grant_id == REQ1) ? req_char1 : req_char0;
        disp_src_d    = grant_id;
        last_grant_d  = grant_id;
        disp_strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      disp_char_q   <= IDLE_CHAR;
      disp_src_q    <= REQ0;
      disp_strobe_q <= 1'b0;
      last_grant_q  <= REQ1;
    end else begin
      state_q       <= state_d;
      disp_char_q   <= disp_char_d;
      disp_src_q    <= disp_src_d;
      disp_strobe_q <= disp_strobe_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign disp_char   = disp_char_q;
  assign disp_src    = disp_src_q;
  assign disp_strobe = disp_strobe_q;
  assign busy        = (state_q == SHOW);

endmodule
